// File: rtl/window_buffer_pkg.sv
// Shared types and constants for the 11x11 window-buffer controller and datapath.
package window_buffer_pkg;

    localparam int WIN_SIZE  = 11;
    localparam int THRESHOLD = 8;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        GAP,
        DONE,
        RELEASE
    } state_t;

    // Counter width that stays legal when only a single gap cycle is requested.
    function automatic int gap_cnt_width(input int gap_cycles);
        return (gap_cycles > 1) ? $clog2(gap_cycles) : 1;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Parameterised 1-bit shift register; aligns the window-valid strobe with the datapath outputs.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_shift;

    // NOTE: every stage is reset; a stale 1 left in the chain would emit a false window after reset.
    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_shift <= '0;
                else        r_shift <= i_d;
            end
        end else begin : g_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_shift <= '0;
                else        r_shift <= {r_shift[DEPTH-2:0], i_d};
            end
        end
    endgenerate

    assign o_q = r_shift[DEPTH-1];

endmodule

// File: rtl/window_buffer_11x11_ctrl.sv
// Sequencing controller for the 11x11 window buffer: row gating, inter-row flush gap,
// datapath rewind via progress_done_o and window-valid alignment.
module window_buffer_11x11_ctrl
    import window_buffer_pkg::*;
#(
    parameter int GAP_CYCLES  = 11,
    parameter int VALID_DELAY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic in_valid_i,
    input  logic i_col_eq_max_i,
    input  logic i_col_ge_threshold_i,
    input  logic i_row_eq_max_i,
    output logic count_en_o,
    output logic progress_done_o,
    output logic window_valid_o,
    output logic busy_o,
    output logic frame_done_o
);

    localparam int              CNT_W    = gap_cnt_width(GAP_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_gap_cnt;
    logic [CNT_W-1:0] w_gap_cnt_next;
    logic             r_progress_done;
    logic             r_frame_done;
    logic             r_busy;
    logic             w_qualify;

    // NOTE: defaults first, so every path assigns every variable and no latch is inferred.
    always_comb begin
        w_next_state   = r_state;
        w_gap_cnt_next = r_gap_cnt;
        case (r_state)
            IDLE: begin
                if (start_i) w_next_state = RUN;
            end
            RUN: begin
                // Row end does not wait for in_valid_i: the datapath clears its column counter anyway.
                if (i_col_eq_max_i) begin
                    w_next_state   = GAP;
                    w_gap_cnt_next = GAP_LOAD;
                end
            end
            GAP: begin
                if (r_gap_cnt == '0) begin
                    w_next_state = i_row_eq_max_i ? DONE : RUN;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - CNT_W'(1);
                end
            end
            DONE:    w_next_state = RELEASE;
            RELEASE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_gap_cnt       <= '0;
            r_busy          <= 1'b0;
            r_progress_done <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_gap_cnt       <= w_gap_cnt_next;
            r_busy          <= (w_next_state != IDLE);
            r_progress_done <= (w_next_state == DONE);
            r_frame_done    <= (w_next_state == RELEASE);
        end
    end

    assign count_en_o = (r_state == RUN) && in_valid_i;
    assign w_qualify  = count_en_o && i_col_ge_threshold_i;

    valid_delay_line #(
        .DEPTH (VALID_DELAY)
    ) u_valid_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_qualify),
        .o_q   (window_valid_o)
    );

    assign progress_done_o = r_progress_done;
    assign frame_done_o    = r_frame_done;
    assign busy_o          = r_busy;

endmodule

// File: tb/tb_window_buffer_11x11_ctrl.sv
// Scoreboard bench for window_buffer_11x11_ctrl with a small behavioural datapath (20 columns, 3 output rows).
module tb_window_buffer_11x11_ctrl;

    localparam int COLS     = 20;
    localparam int OUT_ROWS = 3;

    logic clk        = 1'b0;
    logic rst_n      = 1'b1;
    logic start_i    = 1'b0;
    logic in_valid_i = 1'b0;
    logic force_eq   = 1'b0;
    logic col_eq_max, col_ge, row_eq_max;
    logic count_en_o, progress_done_o, window_valid_o, busy_o, frame_done_o;

    int   cyc     = 0;
    int   m_col   = 0;
    int   m_row   = 0;
    logic prev_pd = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   n_fdone = 0;
    int   s;
    int   n_fd0;
    int   n_cen;
    int   t_gap;
    logic t_run;

    typedef enum int {EV_WIN, EV_PDONE, EV_FDONE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } ev_t;
    ev_t exp_q[$];

    window_buffer_11x11_ctrl #(
        .GAP_CYCLES  (11),
        .VALID_DELAY (2)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_i              (start_i),
        .in_valid_i           (in_valid_i),
        .i_col_eq_max_i       (col_eq_max),
        .i_col_ge_threshold_i (col_ge),
        .i_row_eq_max_i       (row_eq_max),
        .count_en_o           (count_en_o),
        .progress_done_o      (progress_done_o),
        .window_valid_o       (window_valid_o),
        .busy_o               (busy_o),
        .frame_done_o         (frame_done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural datapath: column/row counters, rewound on the falling edge of progress_done_o.
    assign col_eq_max = ((m_col == COLS - 1) && count_en_o) || force_eq;
    assign col_ge     = (m_col > 8);
    assign row_eq_max = (m_row == OUT_ROWS);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_col   <= 0;
            m_row   <= 0;
            prev_pd <= 1'b0;
        end else begin
            prev_pd <= progress_done_o;
            if (prev_pd && !progress_done_o) begin
                m_col <= 0;
                m_row <= 0;
            end else if (col_eq_max) begin
                m_col <= 0;
                m_row <= m_row + 1;
            end else if (count_en_o) begin
                m_col <= m_col + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_kind_t kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Held-high frame started at cycle st: rows run st+1+31r .. st+20+31r, windows lag by 2.
    task automatic push_frame(input int st);
        for (int r = 0; r < OUT_ROWS; r++)
            for (int j = 11; j <= 21; j++)
                push(EV_WIN, st + 1 + 31 * r + j);
        push(EV_PDONE, st + 94);
        push(EV_FDONE, st + 95);
    endtask

    task automatic sb_pop(input ev_kind_t kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected_%s: got event at cycle %0d, expected none", kind.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            check({"sb_kind_", kind.name()}, kind, e.kind);
            if (e.cyc >= 0) check({"sb_cycle_", kind.name()}, cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (window_valid_o)  sb_pop(EV_WIN);
            if (progress_done_o) sb_pop(EV_PDONE);
            if (frame_done_o) begin
                sb_pop(EV_FDONE);
                n_fdone++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic exp_cen(input int rel);
        return (rel >= 1 && rel <= 20) || (rel >= 32 && rel <= 51) || (rel >= 63 && rel <= 82);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check("rst_count_en", count_en_o, 0);
        check("rst_progress_done", progress_done_o, 0);
        check("rst_window_valid", window_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_frame_done", frame_done_o, 0);
        step();
        step();
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a row, with windows in flight
        step();
        start_i    = 1'b1;
        in_valid_i = 1'b1;
        s          = cyc;
        push(EV_WIN, s + 12);
        push(EV_WIN, s + 13);
        push(EV_WIN, s + 14);
        for (int k = 1; k <= 14; k++) begin
            step();
            start_i = 1'b0;
        end
        @(negedge clk);
        check("pre_reset_busy", busy_o, 1);
        check("pre_reset_window_valid", window_valid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count_en", count_en_o, 0);
        check("async_rst_window_valid", window_valid_o, 0);
        check("async_rst_busy", busy_o, 0);
        check("async_rst_progress_done", progress_done_o, 0);
        check("async_rst_frame_done", frame_done_o, 0);
        in_valid_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Two held-high frames; stray starts in RUN/GAP/DONE, restart right after frame_done_o
        step();
        start_i    = 1'b1;
        in_valid_i = 1'b1;
        s          = cyc;
        push_frame(s);
        push_frame(s + 96);
        @(negedge clk);
        check("idle_count_en", count_en_o, 0);
        check("idle_busy", busy_o, 0);
        for (int k = 1; k <= 192; k++) begin
            int rel;
            step();
            start_i = (k == 5 || k == 25 || k == 94 || k == 96);
            rel     = (k < 96) ? k : k - 96;
            @(negedge clk);
            check($sformatf("frame_count_en_k%0d", k), count_en_o, exp_cen(rel));
            check($sformatf("frame_busy_k%0d", k), busy_o, (rel >= 1 && rel <= 95));
            if (k == 96 || k == 192) begin
                check("dp_col_rewound", m_col, 0);
                check("dp_row_rewound", m_row, 0);
            end
        end
        start_i    = 1'b0;
        in_valid_i = 1'b0;

        // Row end without in_valid_i still enters GAP; data during GAP is dropped
        do_reset();
        step();
        start_i = 1'b1;
        step();
        start_i    = 1'b0;
        in_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) step();
        step();
        in_valid_i = 1'b0;
        force_eq   = 1'b1;
        @(negedge clk);
        check("eq_novalid_count_en", count_en_o, 0);
        check("eq_novalid_busy", busy_o, 1);
        step();
        force_eq   = 1'b0;
        in_valid_i = 1'b1;
        for (int g = 0; g < 11; g++) begin
            @(negedge clk);
            check($sformatf("gap_drop_%0d", g), count_en_o, 0);
            step();
        end
        @(negedge clk);
        check("run_resume_count_en", count_en_o, 1);
        in_valid_i = 1'b0;
        do_reset();

        // Bubbly input, about 50% valid
        n_fd0 = n_fdone;
        n_cen = 0;
        t_gap = 0;
        for (int j = 0; j < OUT_ROWS * 11; j++) push(EV_WIN, -1);
        push(EV_PDONE, -1);
        push(EV_FDONE, -1);
        step();
        start_i = 1'b1;
        @(negedge clk);
        t_run = 1'b1;
        for (int b = 0; b < 1000 && n_fdone == n_fd0; b++) begin
            step();
            start_i    = 1'b0;
            in_valid_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bubbly_count_en", count_en_o, t_run ? in_valid_i : 1'b0);
            if (count_en_o) n_cen++;
            if (t_run && col_eq_max) begin
                t_run = 1'b0;
                t_gap = 11;
            end else if (t_gap > 0) begin
                t_gap--;
                if (t_gap == 0) t_run = !row_eq_max;
            end
        end
        check("bubbly_frame_done_count", n_fdone - n_fd0, 1);
        check("bubbly_columns_counted", n_cen, COLS * OUT_ROWS);
        in_valid_i = 1'b0;
        for (int k = 0; k < 20; k++) step();
        @(negedge clk);
        check("bubbly_no_second_frame_done", n_fdone - n_fd0, 1);
        check("bubbly_idle_busy", busy_o, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
